// File: rtl/bullet_collider.sv
// Raster-time bullet/asteroid collision detector: accumulates hits over a frame, then
// reports held reset/hit flags and a saturating score. Optional ship collision: BULLET_COLLIDER_SHIP_EN.
module bullet_collider #(
    parameter int NUM_AST     = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int HOLD_CYCLES = 400000,
    parameter int SCORE_W     = 16
) (
    input  logic               clk_25mhz,
    input  logic               resetn,
    input  logic [9:0]         px,
    input  logic [9:0]         py,
    input  logic [3:0]         bullet_pixel,
    input  logic [NUM_AST-1:0] ast_pixel,
    input  logic               ship_pixel,
    output logic [3:0]         bullet_reset,
    output logic [NUM_AST-1:0] ast_hit,
    output logic               ship_hit,
    output logic [SCORE_W-1:0] score
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int PC_W  = $clog2(NUM_AST + 1);
    localparam int SUM_W = SCORE_W + PC_W;
    localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);
    localparam logic [SUM_W-1:0] SCORE_MAX = {{PC_W{1'b0}}, {SCORE_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_AST-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < NUM_AST; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        REPORT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         b_stk_r;
    logic [NUM_AST-1:0] a_stk_r;
    logic [3:0]         bullet_reset_r;
    logic [NUM_AST-1:0] ast_hit_r;
    logic [SCORE_W-1:0] score_r;

    logic               active_s;
    logic               frame_end_s;
    logic [3:0]         b_pair_s;
    logic [NUM_AST-1:0] a_pair_s;
    logic [SUM_W-1:0]   sum_s;
    logic [SCORE_W-1:0] score_next_s;

    // Per-pixel pair detection: a bullet hits if any asteroid shares its pixel, and vice versa.
    always_comb begin
        active_s    = (px < H_LIM) && (py < V_LIM);
        frame_end_s = (px == 10'd0) && (py == V_LIM);
        b_pair_s    = 4'b0000;
        a_pair_s    = {NUM_AST{1'b0}};
        if (active_s) begin
            b_pair_s = bullet_pixel & {4{|ast_pixel}};
            a_pair_s = ast_pixel & {NUM_AST{|bullet_pixel}};
        end else begin
            b_pair_s = 4'b0000;
            a_pair_s = {NUM_AST{1'b0}};
        end
    end

    // Saturating score update from the asteroids destroyed this frame.
    always_comb begin
        sum_s        = {{PC_W{1'b0}}, score_r} + {{SCORE_W{1'b0}}, popcount(a_stk_r)};
        score_next_s = score_r;
        if (sum_s > SCORE_MAX) begin
            score_next_s = SCORE_MAX[SCORE_W-1:0];
        end else begin
            score_next_s = sum_s[SCORE_W-1:0];
        end
    end

    // Frame hit accumulators; REPORT hands them off and restarts accumulation.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            b_stk_r <= 4'b0000;
            a_stk_r <= {NUM_AST{1'b0}};
        end else if (state_r == REPORT) begin
            b_stk_r <= b_pair_s;
            a_stk_r <= a_pair_s;
        end else begin
            b_stk_r <= b_stk_r | b_pair_s;
            a_stk_r <= a_stk_r | a_pair_s;
        end
    end

    // Report/hold sequencer with registered outputs.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state_r        <= SCAN;
            cnt_r          <= {CNT_W{1'b0}};
            bullet_reset_r <= 4'b0000;
            ast_hit_r      <= {NUM_AST{1'b0}};
            score_r        <= {SCORE_W{1'b0}};
        end else begin
            case (state_r)
                SCAN: begin
                    if (frame_end_s) begin
                        state_r <= REPORT;
                    end
                end
                REPORT: begin
                    bullet_reset_r <= b_stk_r;
                    ast_hit_r      <= a_stk_r;
                    score_r        <= score_next_s;
                    cnt_r          <= CNT_LOAD;
                    state_r        <= HOLD;
                end
                HOLD: begin
                    // A new frame end pre-empts the hold and replaces the outputs.
                    if (frame_end_s) begin
                        state_r <= REPORT;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        bullet_reset_r <= 4'b0000;
                        ast_hit_r      <= {NUM_AST{1'b0}};
                        state_r        <= SCAN;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    bullet_reset_r <= 4'b0000;
                    ast_hit_r      <= {NUM_AST{1'b0}};
                    state_r        <= SCAN;
                end
            endcase
        end
    end

`ifdef BULLET_COLLIDER_SHIP_EN
    logic ship_hit_r;

    // Ship damage latches until the next hard reset.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            ship_hit_r <= 1'b0;
        end else if (active_s && ship_pixel && (|ast_pixel)) begin
            ship_hit_r <= 1'b1;
        end else begin
            ship_hit_r <= ship_hit_r;
        end
    end

    assign ship_hit = ship_hit_r;
`else
    logic ship_unused_s;
    assign ship_unused_s = ship_pixel;
    assign ship_hit      = 1'b0;
`endif

    assign bullet_reset = bullet_reset_r;
    assign ast_hit      = ast_hit_r;
    assign score        = score_r;

endmodule

// File: tb/tb_bullet_collider.sv
// Table-driven, scoreboarded bench for bullet_collider (HOLD_CYCLES=8, SCORE_W=4, NUM_AST=8).
module tb_bullet_collider;
    logic       clk_25mhz = 1'b0;
    logic       resetn;
    logic [9:0] px, py;
    logic [3:0] bullet_pixel;
    logic [7:0] ast_pixel;
    logic       ship_pixel;
    logic [3:0] bullet_reset;
    logic [7:0] ast_hit;
    logic       ship_hit;
    logic [3:0] score;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] x0, y0;
        logic [3:0] bp0;
        logic [7:0] ap0;
        logic [9:0] x1, y1;
        logic [3:0] bp1;
        logic [7:0] ap1;
        logic [3:0] br;
        logic [7:0] ah;
        logic [3:0] sc;
    } vec_t;

    typedef struct {
        logic [3:0] br;
        logic [7:0] ah;
        logic [3:0] sc;
    } exp_t;

    vec_t vecs[9];
    exp_t sb_q[$];
    exp_t e;

    bullet_collider #(.NUM_AST(8), .H_ACTIVE(640), .V_ACTIVE(480), .HOLD_CYCLES(8), .SCORE_W(4)) dut (
        .clk_25mhz(clk_25mhz), .resetn(resetn), .px(px), .py(py),
        .bullet_pixel(bullet_pixel), .ast_pixel(ast_pixel), .ship_pixel(ship_pixel),
        .bullet_reset(bullet_reset), .ast_hit(ast_hit), .ship_hit(ship_hit), .score(score)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [3:0] bp,
                         input logic [7:0] ap, input logic sp);
        @(negedge clk_25mhz);
        px = x; py = y; bullet_pixel = bp; ast_pixel = ap; ship_pixel = sp;
    endtask

    task automatic idle();
        drive(10'd320, 10'd100, 4'b0000, 8'h00, 1'b0);
    endtask

    // Frame end sampled at the next edge E0; the pushed expectation is due after E1.
    task automatic frame_end(input exp_t ex);
        drive(10'd0, 10'd480, 4'b0000, 8'h00, 1'b0);
        sb_q.push_back(ex);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic hold_bad;
        exp_t ex;
        drive(v.x0, v.y0, v.bp0, v.ap0, 1'b0);
        drive(v.x1, v.y1, v.bp1, v.ap1, 1'b0);
        idle();
        ex.br = v.br; ex.ah = v.ah; ex.sc = v.sc;
        frame_end(ex);
        drive(10'd1, 10'd480, 4'b0000, 8'h00, 1'b0);
        check({tag, "_early"}, {24'd0, bullet_reset, ast_hit}, 32'd0);
        @(negedge clk_25mhz);
        ex = sb_q.pop_front();
        check({tag, "_br"}, {28'd0, bullet_reset}, {28'd0, ex.br});
        check({tag, "_ah"}, {24'd0, ast_hit}, {24'd0, ex.ah});
        check({tag, "_score"}, {28'd0, score}, {28'd0, ex.sc});
        hold_bad = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk_25mhz);
            if (bullet_reset !== ex.br || ast_hit !== ex.ah) hold_bad = 1'b1;
        end
        check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
        @(negedge clk_25mhz);
        check({tag, "_drop"}, {24'd0, bullet_reset, ast_hit}, 32'd0);
        idle();
    endtask

    initial begin
        logic hold_bad;
        vecs[0] = '{10'd100, 10'd50,  4'b0010, 8'h04, 10'd320, 10'd100, 4'b0000, 8'h00, 4'b0010, 8'h04, 4'd1};
        vecs[1] = '{10'd200, 10'd10,  4'b0001, 8'h02, 10'd300, 10'd20,  4'b0001, 8'h20, 4'b0001, 8'h22, 4'd3};
        vecs[2] = '{10'd5,   10'd5,   4'b1001, 8'h80, 10'd320, 10'd100, 4'b0000, 8'h00, 4'b1001, 8'h80, 4'd4};
        vecs[3] = '{10'd640, 10'd100, 4'b1111, 8'hFF, 10'd10,  10'd480, 4'b1111, 8'hFF, 4'b0000, 8'h00, 4'd4};
        vecs[4] = '{10'd1,   10'd1,   4'b0100, 8'h00, 10'd2,   10'd2,   4'b0000, 8'hFF, 4'b0000, 8'h00, 4'd4};
        vecs[5] = '{10'd639, 10'd479, 4'b1000, 8'h01, 10'd320, 10'd100, 4'b0000, 8'h00, 4'b1000, 8'h01, 4'd5};
        vecs[6] = '{10'd0,   10'd0,   4'b0001, 8'hFF, 10'd1,   10'd2,   4'b0010, 8'h01, 4'b0011, 8'hFF, 4'd13};
        vecs[7] = '{10'd7,   10'd9,   4'b0100, 8'h01, 10'd320, 10'd100, 4'b0000, 8'h00, 4'b0100, 8'h01, 4'd14};
        vecs[8] = '{10'd8,   10'd9,   4'b0010, 8'h0E, 10'd320, 10'd100, 4'b0000, 8'h00, 4'b0010, 8'h0E, 4'd15};

        resetn = 1'b0;
        px = 10'd320; py = 10'd100; bullet_pixel = 4'b0000; ast_pixel = 8'h00; ship_pixel = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        check("reset_outs", {19'd0, ship_hit, score, bullet_reset, ast_hit}, 32'd0);
        resetn = 1'b1;
        idle();

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Hard reset in the middle of a hold drops everything without a clock edge.
        drive(10'd50, 10'd60, 4'b0010, 8'h08, 1'b0);
        idle();
        e.br = 4'b0010; e.ah = 8'h08; e.sc = 4'd15;
        frame_end(e);
        drive(10'd1, 10'd480, 4'b0000, 8'h00, 1'b0);
        @(negedge clk_25mhz);
        e = sb_q.pop_front();
        check("rst_pre_br", {28'd0, bullet_reset}, {28'd0, e.br});
        repeat (2) @(negedge clk_25mhz);
        #5 resetn = 1'b0;
        #1;
        check("rst_async", {24'd0, score, bullet_reset}, 32'd0);
        check("rst_async_ah", {24'd0, ast_hit}, 32'd0);
        @(negedge clk_25mhz);
        resetn = 1'b1;
        idle();

        // Frame end during hold reloads the outputs and restarts the hold count.
        drive(10'd10, 10'd10, 4'b0001, 8'h01, 1'b0);
        idle();
        e.br = 4'b0001; e.ah = 8'h01; e.sc = 4'd1;
        frame_end(e);
        drive(10'd1, 10'd480, 4'b0000, 8'h00, 1'b0);
        @(negedge clk_25mhz);
        e = sb_q.pop_front();
        check("rt_first_br", {28'd0, bullet_reset}, {28'd0, e.br});
        check("rt_first_score", {28'd0, score}, {28'd0, e.sc});
        repeat (2) @(negedge clk_25mhz);
        drive(10'd30, 10'd30, 4'b0100, 8'h40, 1'b0);
        e.br = 4'b0100; e.ah = 8'h40; e.sc = 4'd2;
        frame_end(e);
        drive(10'd1, 10'd480, 4'b0000, 8'h00, 1'b0);
        check("rt_still_first", {24'd0, ast_hit}, 32'h01);
        @(negedge clk_25mhz);
        e = sb_q.pop_front();
        check("rt_second_br", {28'd0, bullet_reset}, {28'd0, e.br});
        check("rt_second_ah", {24'd0, ast_hit}, {24'd0, e.ah});
        check("rt_second_score", {28'd0, score}, {28'd0, e.sc});
        hold_bad = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk_25mhz);
            if (bullet_reset !== e.br || ast_hit !== e.ah) hold_bad = 1'b1;
        end
        check("rt_hold", {31'd0, hold_bad}, 32'd0);
        @(negedge clk_25mhz);
        check("rt_drop", {24'd0, bullet_reset, ast_hit}, 32'd0);

        // Ship collision: ship alone does nothing, ship over asteroid 0 latches.
        drive(10'd10, 10'd10, 4'b0000, 8'h00, 1'b1);
        idle();
        check("ship_no_ast", {31'd0, ship_hit}, 32'd0);
        drive(10'd10, 10'd10, 4'b0000, 8'h01, 1'b1);
        idle();
`ifdef BULLET_COLLIDER_SHIP_EN
        check("ship_set", {31'd0, ship_hit}, 32'd1);
        repeat (5) @(negedge clk_25mhz);
        check("ship_held", {31'd0, ship_hit}, 32'd1);
`else
        check("ship_tied", {31'd0, ship_hit}, 32'd0);
        repeat (5) @(negedge clk_25mhz);
        check("ship_tied_later", {31'd0, ship_hit}, 32'd0);
`endif
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
